broadcaster: RTL and testbench
==============================

BROADCASTER -- requirements
Module: broadcaster

Interface
REQ-001 Parameter N, default 16, operand width of each broadcast bus; legal range N >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 pin_a  input  1  source bit for bus a.
REQ-005 pin_b  input  1  source bit for bus b.
REQ-006 mode  input  2  pattern select: 0 broadcast, 1 checkerboard, 2 walking-one, 3 hold.
REQ-007 a  output  N  registered operand-A pattern.
REQ-008 b  output  N  registered operand-B pattern.
REQ-009 cin  output  1  registered carry-in for the downstream adder.
REQ-010 pat_valid  output  1  registered; high once outputs reflect sampled inputs.

Function
REQ-011 All outputs SHALL be registered, with a latency of exactly one clk edge from pin_a/pin_b/mode to a/b/cin.
REQ-012 Mode 0: a SHALL be N copies of pin_a, b SHALL be N copies of pin_b, and cin SHALL equal pin_a.
REQ-013 Mode 1: bit i of a SHALL be pin_a XOR (i mod 2), bit i of b SHALL be pin_b XOR (i mod 2), and cin SHALL equal pin_a.
REQ-014 Mode 2 (when compiled in): an internal index idx (width clog2(N)) SHALL select one bit.
REQ-015 Mode 2: a SHALL be one-hot at idx when pin_a=1 and the inverted one-hot when pin_a=0; b SHALL be N copies of pin_b; cin SHALL be 0.
REQ-016 idx SHALL increment by 1 on each clk edge while mode=2, and SHALL wrap from N-1 to 0.
REQ-017 idx SHALL clear to 0 on any edge where mode!=2, so re-entering mode 2 always starts at bit 0.
REQ-018 Mode 3: a, b and cin SHALL hold their previous values, and idx SHALL be 0.
REQ-019 pat_valid SHALL be 0 in reset and SHALL go to 1 on the first clk edge after rst_n deasserts, then stay 1 until the next reset.
REQ-020 A mode change SHALL take effect on the same edge that samples it, with no idle cycle.

Reset
REQ-021 rst_n low SHALL immediately force a, b, cin, pat_valid and idx to 0, independent of clk.
REQ-022 Reset asserted mid-pattern SHALL abort the pattern, and after release mode 2 SHALL restart at idx 0.
REQ-023 Reset release SHALL be synchronised by the integrator, not inside this block.

Configuration
REQ-024 Macro BROADCASTER_WALK_EN SHALL gate walking-one support.
REQ-025 With BROADCASTER_WALK_EN defined, mode 2 SHALL behave per REQ-014 to REQ-017.
REQ-026 Without BROADCASTER_WALK_EN, the idx register and its logic SHALL be absent, and mode 2 SHALL behave exactly as mode 0.

Structure
REQ-027 Package broadcaster_pkg SHALL hold the mode enumeration (MODE_BCAST=0, MODE_CHECK=1, MODE_WALK=2, MODE_HOLD=3) and the default width constant 16.
REQ-028 One sub-module, broadcaster_walk_ctr (wrap-around index counter with synchronous clear and asynchronous active-low reset), SHALL be instantiated only under BROADCASTER_WALK_EN.
REQ-029 The pattern muxing SHALL be written as combinational logic feeding a single output register stage.

Verification
REQ-030 Reset then mode=0, pin_a=0, pin_b=1, one edge -> a=16'h0000, b=16'hFFFF, cin=0, pat_valid=1.
REQ-031 Mode=0, pin_a=1, pin_b=0, one edge -> a=16'hFFFF, b=16'h0000, cin=1.
REQ-032 Mode=1, pin_a=0, pin_b=1 -> a=16'hAAAA, b=16'h5555, cin=0.
REQ-033 Mode=2 with the macro defined, pin_a=1, pin_b=0, 17 edges -> a steps 16'h0001, 16'h0002, ... 16'h8000, then wraps to 16'h0001.
REQ-034 Mode=3 after a=16'hFFFF, then toggle pin_a/pin_b -> a, b and cin remain unchanged.
REQ-035 rst_n pulsed low between clk edges during mode 2 -> all outputs 0 immediately; after release the walk restarts at 16'h0001.

Source files
------------

// File: rtl/broadcaster_pkg.sv
// Shared definitions for the broadcaster pattern generator: the pattern-mode
// enumeration, the default operand width and a small width helper.
// The walking-one pattern is compiled in only when BROADCASTER_WALK_EN is defined.
package broadcaster_pkg;

    // Default operand width of each broadcast bus.
    localparam int BCAST_N_DEFAULT = 16;

    // Pattern select values presented on the 2-bit mode input.
    typedef enum logic [1:0] {
        MODE_BCAST = 2'd0,
        MODE_CHECK = 2'd1,
        MODE_WALK  = 2'd2,
        MODE_HOLD  = 2'd3
    } mode_e;

    // Width of an index that can address every bit of an n-bit bus.
    // Never returns less than 1 so the index register is always legal.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/broadcaster_walk_ctr.sv
// Wrap-around bit index for the walking-one pattern.
// Counts 0 .. N-1 and wraps to 0; a synchronous clear returns it to 0 so the
// walk always restarts at bit 0, and the asynchronous active-low reset does
// the same without waiting for a clock edge.
// Only instantiated when BROADCASTER_WALK_EN is defined.
module broadcaster_walk_ctr #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    output logic [W-1:0] idx
);

    // Last legal index; reaching it wraps the count back to 0.
    localparam logic [W-1:0] LAST = W'(N - 1);

    // Index register: clear has priority, otherwise step and wrap at N-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (idx == LAST) begin
            idx <= '0;
        end else begin
            idx <= idx + W'(1);
        end
    end

endmodule

// File: rtl/broadcaster.sv
// Operand pattern generator feeding a downstream adder.
// Builds the next a/b/cin values combinationally from pin_a, pin_b and mode
// and captures them in a single output register stage, giving exactly one
// clock of latency from the inputs to the outputs.
// Modes: 0 broadcast, 1 checkerboard, 2 walking-one, 3 hold.
// Build option: define BROADCASTER_WALK_EN to compile in the walking-one
// pattern; without it, mode 2 produces the same outputs as mode 0 and the
// index counter does not exist.
module broadcaster
    import broadcaster_pkg::*;
#(
    parameter int N = BCAST_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pin_a,
    input  logic         pin_b,
    input  logic [1:0]   mode,
    output logic [N-1:0] a,
    output logic [N-1:0] b,
    output logic         cin,
    output logic         pat_valid
);

    mode_e        mode_sel;
    logic [N-1:0] odd_mask;
    logic [N-1:0] a_nxt;
    logic [N-1:0] b_nxt;
    logic         cin_nxt;

    assign mode_sel = mode_e'(mode);

    // Odd bit positions set: XOR with a replicated pin gives the checkerboard.
    for (genvar i = 0; i < N; i++) begin : g_odd_mask
        assign odd_mask[i] = ((i % 2) == 1);
    end

`ifdef BROADCASTER_WALK_EN
    localparam int IW = idx_width(N);

    logic [IW-1:0] idx;
    logic [N-1:0]  one_hot;

    // The counter runs only while mode selects the walk; any other mode
    // clears it so re-entering the walk starts at bit 0.
    broadcaster_walk_ctr #(
        .N (N),
        .W (IW)
    ) u_walk_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mode_sel != MODE_WALK),
        .idx   (idx)
    );

    assign one_hot = {{(N-1){1'b0}}, 1'b1} << idx;
`endif

    // Next-pattern mux; hold mode (and any unlisted value) keeps the outputs.
    always_comb begin
        a_nxt   = a;
        b_nxt   = b;
        cin_nxt = cin;
        case (mode_sel)
            MODE_BCAST: begin
                a_nxt   = {N{pin_a}};
                b_nxt   = {N{pin_b}};
                cin_nxt = pin_a;
            end
            MODE_CHECK: begin
                a_nxt   = {N{pin_a}} ^ odd_mask;
                b_nxt   = {N{pin_b}} ^ odd_mask;
                cin_nxt = pin_a;
            end
            MODE_WALK: begin
`ifdef BROADCASTER_WALK_EN
                a_nxt   = pin_a ? one_hot : ~one_hot;
                b_nxt   = {N{pin_b}};
                cin_nxt = 1'b0;
`else
                a_nxt   = {N{pin_a}};
                b_nxt   = {N{pin_b}};
                cin_nxt = pin_a;
`endif
            end
            MODE_HOLD: begin
                a_nxt   = a;
                b_nxt   = b;
                cin_nxt = cin;
            end
            default: begin
                a_nxt   = a;
                b_nxt   = b;
                cin_nxt = cin;
            end
        endcase
    end

    // Single output register stage; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a         <= '0;
            b         <= '0;
            cin       <= 1'b0;
            pat_valid <= 1'b0;
        end else begin
            a         <= a_nxt;
            b         <= b_nxt;
            cin       <= cin_nxt;
            pat_valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_broadcaster.sv
// Directed testbench for broadcaster (N = 16).
// Each step drives the inputs, pushes the hand-computed expected outputs into
// a queue and compares them against the registered outputs 1 ns after the
// next rising edge. Expected walking-one values depend on BROADCASTER_WALK_EN.
module tb_broadcaster;
    import broadcaster_pkg::*;

    localparam int N  = 16;
    localparam int EW = 2 * N + 2;

    logic         clk;
    logic         rst_n;
    logic         pin_a;
    logic         pin_b;
    logic [1:0]   mode;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         cin;
    logic         pat_valid;

    int checks   = 0;
    int failures = 0;

    // Expected output vectors: {pat_valid, cin, b, a}.
    logic [EW-1:0] exp_q[$];

    broadcaster #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pin_a     (pin_a),
        .pin_b     (pin_b),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .pat_valid (pat_valid)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [1:0] m, input logic pa, input logic pb);
        mode  = m;
        pin_a = pa;
        pin_b = pb;
    endtask

    // Advance to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic push_exp(input logic [N-1:0] ea, input logic [N-1:0] eb,
                            input logic ec, input logic ev);
        exp_q.push_back({ev, ec, eb, ea});
    endtask

    task automatic check_val(input string tag, input logic [N-1:0] obs,
                             input logic [N-1:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic compare_out(input string tag);
        logic [EW-1:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s: observed=empty expected queue entry", tag);
        end else begin
            e = exp_q.pop_front();
            check_val({tag, ".a"}, a, e[N-1:0]);
            check_val({tag, ".b"}, b, e[2*N-1:N]);
            check_val({tag, ".cin"}, N'(cin), N'(e[2*N]));
            check_val({tag, ".pat_valid"}, N'(pat_valid), N'(e[2*N+1]));
        end
    endtask

    // One clocked step: drive, predict, clock, compare.
    task automatic step(input string tag, input logic [1:0] m, input logic pa, input logic pb,
                        input logic [N-1:0] ea, input logic [N-1:0] eb, input logic ec);
        drive(m, pa, pb);
        push_exp(ea, eb, ec, 1'b1);
        tick();
        compare_out(tag);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n = 1'b0;
        drive(2'd0, 1'b1, 1'b1);
        tick();
        tick();
        push_exp(16'h0000, 16'h0000, 1'b0, 1'b0);
        compare_out("reset_state");

        #2 rst_n = 1'b1;

        // Broadcast
        step("bcast_a0_b1", 2'd0, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b0);
        step("bcast_a1_b0", 2'd0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1);

        // Checkerboard
        step("check_a0_b1", 2'd1, 1'b0, 1'b1, 16'hAAAA, 16'h5555, 1'b0);
        step("check_a1_b0", 2'd1, 1'b1, 1'b0, 16'h5555, 16'hAAAA, 1'b1);

        // Walking one, 17 edges: bit 0 .. bit 15, then wrap to bit 0
        for (int k = 0; k < 17; k++) begin
`ifdef BROADCASTER_WALK_EN
            step($sformatf("walk1_%0d", k), 2'd2, 1'b1, 1'b0,
                 16'h0001 << (k % 16), 16'h0000, 1'b0);
`else
            step($sformatf("walk1_%0d", k), 2'd2, 1'b1, 1'b0,
                 16'hFFFF, 16'h0000, 1'b1);
`endif
        end

        // Inverted walk continues from index 1
`ifdef BROADCASTER_WALK_EN
        step("walk0_1", 2'd2, 1'b0, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0);
        step("walk0_2", 2'd2, 1'b0, 1'b1, 16'hFFFB, 16'hFFFF, 1'b0);
`else
        step("walk0_1", 2'd2, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b0);
        step("walk0_2", 2'd2, 1'b0, 1'b1, 16'h0000, 16'hFFFF, 1'b0);
`endif

        // Set a=FFFF, then hold while toggling the pins
        step("pre_hold", 2'd0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
        step("hold_0", 2'd3, 1'b0, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        step("hold_1", 2'd3, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 1'b1);
        step("hold_2", 2'd3, 1'b0, 1'b0, 16'hFFFF, 16'h0000, 1'b1);

        // Re-entering the walk from hold starts at bit 0
`ifdef BROADCASTER_WALK_EN
        step("reenter_0", 2'd2, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0);
        step("reenter_1", 2'd2, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
        step("reenter_2", 2'd2, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0);
`else
        step("reenter_0", 2'd2, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
        step("reenter_1", 2'd2, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
        step("reenter_2", 2'd2, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
`endif

        // Asynchronous reset mid-walk, between clock edges
        #2 rst_n = 1'b0;
        #1;
        push_exp(16'h0000, 16'h0000, 1'b0, 1'b0);
        compare_out("async_reset");
        tick();
        push_exp(16'h0000, 16'h0000, 1'b0, 1'b0);
        compare_out("reset_hold");
        #2 rst_n = 1'b1;

        // Walk restarts at bit 0 after release
`ifdef BROADCASTER_WALK_EN
        step("restart_0", 2'd2, 1'b1, 1'b0, 16'h0001, 16'h0000, 1'b0);
        step("restart_1", 2'd2, 1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0);
`else
        step("restart_0", 2'd2, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
        step("restart_1", 2'd2, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1);
`endif

        // Immediate switch from walk to checkerboard, no idle cycle
        step("switch_check", 2'd1, 1'b0, 1'b0, 16'hAAAA, 16'hAAAA, 1'b0);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
